pc_sequencer: RTL

//  Program-counter stage directly upstream of instruction_fetch. Generates the word-aligned
//  PC that addresses the synchronous instruction BRAM (1-cycle read latency), then tracks which
//  PC the BRAM output currently belongs to. Handles sequential advance, branch/jump redirect

---
 rtl/pc_sequencer_pkg.sv | 31 +++
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/pc_sequencer.sv | 91 +++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter stage: state encoding, word size,
// default reset PC and the address wrap/align helpers.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Byte-address mask covering exactly imem_words words of instruction memory.
    function automatic logic [31:0] span_mask(input int imem_words);
        logic [31:0] span;
        span = 32'(imem_words * WORD_BYTES);
        return span - 32'd1;
    endfunction

    function automatic logic [31:0] wrap_addr(input logic [31:0] addr,
                                              input logic [31:0] mask);
        return addr & mask;
    endfunction

    function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                               input logic [31:0] mask);
        return {addr[31:2], 2'b00} & mask;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and address signals exchanged between the PC sequencer and the
// fetch/decode side of the pipeline.
interface pc_sequencer_if;

    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;

    modport master (
        input  stall,
        input  redirect,
        input  target,
        input  halt,
        output pc,
        output fetch_pc,
        output pc_plus4,
        output instr_valid,
        output halted
    );

    modport slave (
        output stall,
        output redirect,
        output target,
        output halt,
        input  pc,
        input  fetch_pc,
        input  pc_plus4,
        input  instr_valid,
        input  halted
    );

endinterface

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding a 1-cycle-latency instruction BRAM; tracks which
// PC the BRAM output belongs to and handles redirect, stall and halt.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int          IMEM_WORDS = 16,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    pc_sequencer_if.master    bus
);

    localparam logic [31:0] ADDR_MASK = span_mask(IMEM_WORDS);
    localparam logic [31:0] STEP      = 32'(WORD_BYTES);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            valid_q    <= valid_d;
        end
    end

    // Control inputs only qualify a real instruction, so each is gated by valid_q.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        valid_d    = valid_q;
        unique case (state_q)
            ST_BOOT: begin
                fetch_pc_d = pc_q;
                pc_d       = wrap_addr(pc_q + STEP, ADDR_MASK);
                valid_d    = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (valid_q && bus.halt) begin
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                end else if (valid_q && bus.redirect) begin
                    pc_d       = align_addr(bus.target, ADDR_MASK);
                    fetch_pc_d = pc_q;
                    valid_d    = 1'b0;
                end else if (valid_q && bus.stall) begin
                    pc_d       = pc_q;
                    fetch_pc_d = fetch_pc_q;
                    valid_d    = valid_q;
                end else begin
                    fetch_pc_d = pc_q;
                    pc_d       = wrap_addr(pc_q + STEP, ADDR_MASK);
                    valid_d    = 1'b1;
                end
            end
            ST_HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    // During a stall the BRAM re-reads the held word so its output stays stable.
    always_comb begin
        if (state_q == ST_RUN && bus.stall && valid_q) begin
            bus.pc = fetch_pc_q;
        end else begin
            bus.pc = pc_q;
        end
    end

    assign bus.fetch_pc    = fetch_pc_q;
    assign bus.pc_plus4    = wrap_addr(fetch_pc_q + STEP, ADDR_MASK);
    assign bus.instr_valid = valid_q && (state_q == ST_RUN);
    assign bus.halted      = (state_q == ST_HALT);

endmodule
